// File: rtl/rh_pkg.sv
// Shared definitions for the rhythm-game blocks (score loader consumers,
// beat timing, scoring).
//   - Note code constants (rest, end marker)
//   - Tracker FSM state encoding
//   - Common widths for tempo and note codes
package rh_pkg;

  localparam int TEMPO_W = 26;
  localparam int NOTE_W  = 4;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'h0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A scorable note is anything that is neither a rest nor the end marker.
  function automatic logic is_pitch(input logic [NOTE_W-1:0] note);
    return (note != NOTE_REST) && (note != NOTE_END);
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Free-running beat counter: counts 0..tempo-1 and wraps.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          synchronous clear to 0 (has priority over counting)
//   tempo          beat length in clk cycles (caller holds it stable)
//   beat_end       high while count == tempo-1 (last cycle of the beat)
//   count          current position inside the beat
module beat_timer
  import rh_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               beat_end,
  output logic [TEMPO_W-1:0] count
);

  logic [TEMPO_W-1:0] count_q;

  assign beat_end = (count_q == (tempo - {{(TEMPO_W-1){1'b0}}, 1'b1}));
  assign count    = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear || beat_end) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + {{(TEMPO_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Judges each beat of a song as hit or miss by comparing the player's
// detected pitch with the note at the judgement position, and keeps the
// score / streak / tally registers shown by the overlay.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             one-cycle (re)start pulse, shared with the loader
//   tempo             beat length in cycles, sampled on start
//   judge_note        note currently at the judgement position
//   song_done         loader reports the end marker reached position 0
//   det_note/valid    pitch detector output
//   playing           high while in PLAY
//   score, streak, best_streak, hits, misses   saturating tallies
//   judge_valid       one-cycle pulse the cycle after a scored beat end;
//                     judge_hit is meaningful with it and held afterwards
//                     (no back-pressure: consumers must take it that cycle)
//   state_dbg         current FSM state
//   beat_count_dbg    current position inside the beat
module score_tracker
  import rh_pkg::*;
#(
  parameter int HIT_SHIFT   = 2,
  parameter int BASE_POINTS = 10,
  parameter int STREAK_STEP = 3,
  parameter int MAX_MULT    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [NOTE_W-1:0]  judge_note,
  input  logic               song_done,
  input  logic [NOTE_W-1:0]  det_note,
  input  logic               det_valid,
  output logic               playing,
  output logic [15:0]        score,
  output logic [7:0]         streak,
  output logic [7:0]         best_streak,
  output logic [9:0]         hits,
  output logic [9:0]         misses,
  output logic               judge_valid,
  output logic               judge_hit,
  output logic [1:0]         state_dbg,
  output logic [TEMPO_W-1:0] beat_count_dbg
);

  state_t state_q, state_d;

  logic [TEMPO_W-1:0] tempo_q;
  logic [TEMPO_W-1:0] match_cnt;
  logic [TEMPO_W-1:0] threshold;
  logic [TEMPO_W:0]   match_total;
  logic               beat_end, beat_tick, timer_clear;
  logic               match_now, hit_now, judge_now;
  logic [7:0]         streak_hi, mult, streak_inc;
  logic [16:0]        points, score_sum;

  assign playing   = (state_q == PLAY);
  assign state_dbg = state_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = PLAY;
      PLAY: begin
        if (start)
          state_d = PLAY;
        else if (song_done || (beat_end && judge_note == NOTE_END))
          state_d = DONE;
      end
      DONE: if (start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- beat timing ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   tempo_q <= '0;
    else if (start) tempo_q <= tempo;
  end

  // Held at zero outside PLAY so the first beat after start is a full beat.
  assign timer_clear = start || !playing;

  beat_timer u_beat_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .tempo    (tempo_q),
    .beat_end (beat_end),
    .count    (beat_count_dbg)
  );

  // start wins over a coinciding beat end
  assign beat_tick = playing && beat_end && !start;

  // ---------------- judgement ----------------
  assign match_now   = det_valid && (det_note == judge_note);
  // The beat-end cycle itself counts toward the match total.
  assign match_total = {1'b0, match_cnt} + {{TEMPO_W{1'b0}}, match_now};
  assign threshold   = tempo_q >> HIT_SHIFT;
  assign hit_now     = (match_total >= {1'b0, threshold});
  assign judge_now   = beat_tick && !song_done && is_pitch(judge_note);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= '0;
    end else if (start || !playing || beat_tick) begin
      match_cnt <= '0;
    end else if (match_now && (match_cnt != '1)) begin
      match_cnt <= match_cnt + {{(TEMPO_W-1){1'b0}}, 1'b1};
    end
  end

  // ---------------- scoring arithmetic ----------------
  // Multiplier uses the streak before this hit is counted.
  assign streak_hi  = streak >> STREAK_STEP;
  assign mult       = (streak_hi >= 8'(MAX_MULT - 1)) ? 8'(MAX_MULT)
                                                      : streak_hi + 8'd1;
  assign points     = 17'(BASE_POINTS) * {9'd0, mult};
  assign score_sum  = {1'b0, score} + points;
  assign streak_inc = (streak == 8'hFF) ? streak : streak + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score       <= '0;
      streak      <= '0;
      best_streak <= '0;
      hits        <= '0;
      misses      <= '0;
      judge_valid <= 1'b0;
      judge_hit   <= 1'b0;
    end else if (start) begin
      score       <= '0;
      streak      <= '0;
      best_streak <= '0;
      hits        <= '0;
      misses      <= '0;
      judge_valid <= 1'b0;
      judge_hit   <= 1'b0;
    end else begin
      judge_valid <= judge_now;
      if (judge_now) begin
        judge_hit <= hit_now;
        if (hit_now) begin
          score  <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          streak <= streak_inc;
          hits   <= (hits == 10'h3FF) ? hits : hits + 10'd1;
          if (streak_inc > best_streak) best_streak <= streak_inc;
        end else begin
          streak <= '0;
          misses <= (misses == 10'h3FF) ? misses : misses + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker (tempo 8, HIT_SHIFT 1 -> threshold 4).
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [25:0] tempo;
  logic [3:0]  judge_note;
  logic        song_done;
  logic [3:0]  det_note;
  logic        det_valid;
  logic        playing;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [7:0]  best_streak;
  logic [9:0]  hits;
  logic [9:0]  misses;
  logic        judge_valid;
  logic        judge_hit;
  logic [1:0]  state_dbg;
  logic [25:0] beat_count_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  score_tracker #(.HIT_SHIFT(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .tempo          (tempo),
    .judge_note     (judge_note),
    .song_done      (song_done),
    .det_note       (det_note),
    .det_valid      (det_valid),
    .playing        (playing),
    .score          (score),
    .streak         (streak),
    .best_streak    (best_streak),
    .hits           (hits),
    .misses         (misses),
    .judge_valid    (judge_valid),
    .judge_hit      (judge_hit),
    .state_dbg      (state_dbg),
    .beat_count_dbg (beat_count_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input logic [25:0] t);
    tempo = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full 8-cycle beat: the first n_match cycles carry the judged note.
  task automatic play_beat(input logic [3:0] jn, input int n_match,
                           input logic done_last, input logic exp_valid,
                           input logic exp_hit, input string name);
    int spurious = 0;
    for (int i = 0; i < 8; i++) begin
      judge_note = jn;
      det_valid  = 1'b1;
      det_note   = (i < n_match) ? jn : (jn ^ 4'h1);
      song_done  = done_last && (i == 7);
      @(negedge clk);
      if (i < 7 && judge_valid !== 1'b0) spurious++;
    end
    song_done = 1'b0;
    tests_run++;
    if (spurious != 0) begin
      tests_failed++;
      $display("FAIL %s mid-beat pulse: got %0d pulses, want 0", name, spurious);
    end
    tests_run++;
    if (judge_valid !== exp_valid) begin
      tests_failed++;
      $display("FAIL %s judge_valid: got %b want %b", name, judge_valid, exp_valid);
    end
    if (exp_valid) begin
      tests_run++;
      if (judge_hit !== exp_hit) begin
        tests_failed++;
        $display("FAIL %s judge_hit: got %b want %b", name, judge_hit, exp_hit);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; tempo = 26'd8; judge_note = 4'h0;
    song_done = 1'b0; det_note = 4'h0; det_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !== 52'd0 ||
        {playing, judge_valid, judge_hit, state_dbg} !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset outputs: got %h/%b%b%b st=%0d want 0",
               {score, streak, best_streak, hits, misses},
               playing, judge_valid, judge_hit, state_dbg);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (playing !== 1'b0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL idle_hold: playing=%b state=%0d want 0/0", playing, state_dbg);
    end
  endtask

  task automatic test_basic_hit();
    do_start(26'd8);
    tests_run++;
    if (playing !== 1'b1 || state_dbg !== 2'd1) begin
      tests_failed++;
      $display("FAIL start_play: playing=%b state=%0d want 1/1", playing, state_dbg);
    end
    play_beat(4'h3, 8, 1'b0, 1'b1, 1'b1, "basic_hit");
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !==
        {16'd10, 8'd1, 8'd1, 10'd1, 10'd0}) begin
      tests_failed++;
      $display("FAIL basic_hit counters: score=%0d streak=%0d best=%0d hits=%0d misses=%0d want 10/1/1/1/0",
               score, streak, best_streak, hits, misses);
    end
  endtask

  task automatic test_threshold();
    play_beat(4'h3, 3, 1'b0, 1'b1, 1'b0, "three_of_eight");
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !==
        {16'd10, 8'd0, 8'd1, 10'd1, 10'd1}) begin
      tests_failed++;
      $display("FAIL miss counters: score=%0d streak=%0d best=%0d hits=%0d misses=%0d want 10/0/1/1/1",
               score, streak, best_streak, hits, misses);
    end
    play_beat(4'h3, 4, 1'b0, 1'b1, 1'b1, "four_of_eight");
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !==
        {16'd20, 8'd1, 8'd1, 10'd2, 10'd1}) begin
      tests_failed++;
      $display("FAIL edge_hit counters: score=%0d streak=%0d best=%0d hits=%0d misses=%0d want 20/1/1/2/1",
               score, streak, best_streak, hits, misses);
    end
  endtask

  task automatic test_rest();
    for (int b = 0; b < 3; b++) play_beat(4'h0, b * 3, 1'b0, 1'b0, 1'b0, "rest_beat");
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !==
        {16'd20, 8'd1, 8'd1, 10'd2, 10'd1}) begin
      tests_failed++;
      $display("FAIL rest counters: score=%0d streak=%0d best=%0d hits=%0d misses=%0d want 20/1/1/2/1",
               score, streak, best_streak, hits, misses);
    end
  endtask

  task automatic test_start_vs_beat_end();
    for (int i = 0; i < 8; i++) begin
      judge_note = 4'h3; det_note = 4'h3; det_valid = 1'b1;
      start = (i == 7);
      tempo = 26'd8;
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (judge_valid !== 1'b0 || playing !== 1'b1 ||
        {score, streak, best_streak, hits, misses} !== 52'd0) begin
      tests_failed++;
      $display("FAIL start_beat_end: jv=%b playing=%b counters=%h want 0/1/0",
               judge_valid, playing, {score, streak, best_streak, hits, misses});
    end
    play_beat(4'h3, 8, 1'b0, 1'b1, 1'b1, "after_restart");
    tests_run++;
    if (score !== 16'd10) begin
      tests_failed++;
      $display("FAIL after_restart score: got %0d want 10", score);
    end
  endtask

  task automatic test_streak();
    logic [15:0] exp_score;
    do_start(26'd8);
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !== 52'd0) begin
      tests_failed++;
      $display("FAIL restart clear: got %h want 0", {score, streak, best_streak, hits, misses});
    end
    for (int k = 1; k <= 9; k++) begin
      play_beat(4'h5, 8, 1'b0, 1'b1, 1'b1, "streak_hit");
      exp_score = (k <= 8) ? 16'(10 * k) : 16'd100;
      tests_run++;
      if (score !== exp_score || streak !== 8'(k)) begin
        tests_failed++;
        $display("FAIL streak hit %0d: score=%0d streak=%0d want %0d/%0d",
                 k, score, streak, exp_score, k);
      end
    end
    tests_run++;
    if (best_streak !== 8'd9 || hits !== 10'd9) begin
      tests_failed++;
      $display("FAIL streak best: best=%0d hits=%0d want 9/9", best_streak, hits);
    end
    play_beat(4'h5, 0, 1'b0, 1'b1, 1'b0, "streak_miss");
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !==
        {16'd100, 8'd0, 8'd9, 10'd9, 10'd1}) begin
      tests_failed++;
      $display("FAIL streak miss: score=%0d streak=%0d best=%0d hits=%0d misses=%0d want 100/0/9/9/1",
               score, streak, best_streak, hits, misses);
    end
  endtask

  task automatic test_end_marker();
    play_beat(4'hF, 8, 1'b0, 1'b0, 1'b0, "end_marker");
    tests_run++;
    if (playing !== 1'b0 || state_dbg !== 2'd2 ||
        {score, streak, best_streak, hits, misses} !==
        {16'd100, 8'd0, 8'd9, 10'd9, 10'd1}) begin
      tests_failed++;
      $display("FAIL end_marker: playing=%b state=%0d counters=%h want 0/2/frozen",
               playing, state_dbg, {score, streak, best_streak, hits, misses});
    end
  endtask

  task automatic test_song_done();
    int pulses = 0;
    do_start(26'd8);
    play_beat(4'h7, 8, 1'b0, 1'b1, 1'b1, "pre_done_hit");
    play_beat(4'h7, 8, 1'b1, 1'b0, 1'b0, "done_at_beat_end");
    tests_run++;
    if (playing !== 1'b0 || state_dbg !== 2'd2 ||
        {score, streak, best_streak, hits, misses} !==
        {16'd10, 8'd1, 8'd1, 10'd1, 10'd0}) begin
      tests_failed++;
      $display("FAIL song_done: playing=%b state=%0d counters=%h want 0/2/frozen",
               playing, state_dbg, {score, streak, best_streak, hits, misses});
    end
    for (int i = 0; i < 20; i++) begin
      judge_note = 4'h7; det_note = 4'h7; det_valid = 1'b1;
      @(negedge clk);
      if (judge_valid !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses != 0 || {score, streak, best_streak, hits, misses} !==
        {16'd10, 8'd1, 8'd1, 10'd1, 10'd0} || judge_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_frozen: pulses=%0d counters=%h hit=%b want 0/frozen/1",
               pulses, {score, streak, best_streak, hits, misses}, judge_hit);
    end
    do_start(26'd8);
    tests_run++;
    if (playing !== 1'b1 || judge_hit !== 1'b0 ||
        {score, streak, best_streak, hits, misses} !== 52'd0) begin
      tests_failed++;
      $display("FAIL done_restart: playing=%b hit=%b counters=%h want 1/0/0",
               playing, judge_hit, {score, streak, best_streak, hits, misses});
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    play_beat(4'h2, 8, 1'b0, 1'b1, 1'b1, "pre_reset_hit");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({score, streak, best_streak, hits, misses} !== 52'd0 ||
        {playing, judge_valid, judge_hit, state_dbg} !== 5'd0) begin
      tests_failed++;
      $display("FAIL async_reset: counters=%h flags=%b%b%b state=%0d want 0",
               {score, streak, best_streak, hits, misses},
               playing, judge_valid, judge_hit, state_dbg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      judge_note = 4'h2; det_note = 4'h2; det_valid = 1'b1;
      @(negedge clk);
      if (judge_valid !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses != 0 || playing !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: pulses=%0d playing=%b want 0/0", pulses, playing);
    end
    do_start(26'd8);
    play_beat(4'h2, 8, 1'b0, 1'b1, 1'b1, "post_reset_hit");
    tests_run++;
    if (score !== 16'd10 || hits !== 10'd1) begin
      tests_failed++;
      $display("FAIL post_reset counters: score=%0d hits=%0d want 10/1", score, hits);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_hit();
    test_threshold();
    test_rest();
    test_start_vs_beat_end();
    test_streak();
    test_end_marker();
    test_song_done();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
Downstream consumer of the musical score loader. It watches the note at the judgement position (lowest nibble of the 16-note window) and the player's pitch-detected note, and judges each beat as hit or miss. It maintains score, streak, best streak and hit/miss tallies, which feed the video overlay and the end-of-song screen. It runs a beat timer from the same tempo value and the same start event as the loader, so its judgement windows line up exactly with the loader's note shifts.

Parameters:
HIT_SHIFT, 2, hit threshold is tempo >> HIT_SHIFT matching cycles (default = 25% of the beat)
BASE_POINTS, 10, points per hit before the multiplier
STREAK_STEP, 3, the multiplier increases every 2^STREAK_STEP consecutive hits
MAX_MULT, 4, multiplier ceiling

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; the same event that resets the loader
tempo  in  26  beat length in clk cycles, from the loader's tempo_out; ≥ 4
judge_note  in  4  note at the judgement position, next_notes_out[3:0]
song_done  in  1  high from the loader when the end marker reaches position 0
det_note  in  4  note code from the pitch detector
det_valid  in  1  det_note is meaningful this cycle
playing  out  1  high in PLAY
score  out  16  accumulated points, saturating
streak  out  8  current consecutive hits, saturating
best_streak  out  8  maximum streak seen this song
hits  out  10  hit count, saturating
misses  out  10  miss count, saturating
judge_valid  out  1  one-cycle pulse per scored beat
judge_hit  out  1  result of the last judgement; valid with judge_valid and held after it

Behaviour:
- Note codes: 4'h0 = rest, not scored. 4'hF = end marker. All other codes are pitches.
- Reset (reset_n low, asynchronous): state IDLE, and every output register goes to 0.
- FSM states are IDLE, PLAY and DONE.
  - IDLE→PLAY on start.
  - PLAY→DONE when song_done is high, or when judge_note == 4'hF at a beat end.
  - DONE→PLAY on start.
- A start pulse while in PLAY restarts the song: state stays PLAY and all counters clear.
- playing = (state == PLAY).
- On start from any state:
  - score, streak, best_streak, hits and misses clear to 0.
  - The beat counter and the match counter clear to 0.
  - judge_hit clears to 0.
- Beat counter: counts 0..tempo-1 in PLAY and wraps to 0. beat_end = (count == tempo-1).
- tempo is sampled on start and held for the whole song.
- Match counter: in PLAY it increments each cycle that det_valid && det_note == judge_note. It saturates at 2^26-1 and clears on beat_end.
- Judgement happens on the beat_end cycle. It applies only when judge_note ∉ {0, F}.
  - hit = match_count (including the current cycle) ≥ (tempo_q >> HIT_SHIFT).
  - judge_valid pulses on the following cycle (latency 1), with judge_hit = hit.
- On a hit:
  - mult = min(1 + (streak >> STREAK_STEP), MAX_MULT), using the streak value before the increment.
  - score += BASE_POINTS*mult, saturating at 16'hFFFF.
  - streak += 1, saturating at 255.
  - hits += 1, saturating at 1023.
  - best_streak = max(best_streak, new streak).
- On a miss: streak is set to 0 and misses += 1 (saturating). score is unchanged.
- Rest beats produce no judge_valid pulse and leave every counter unchanged.
- DONE: all outputs freeze. det_note and det_valid are ignored. There is no judge_valid pulse.
- If song_done and beat_end occur on the same cycle, the beat is not judged and the FSM goes to DONE.
- If start and beat_end occur on the same cycle, start has priority and no judgement is made.

Decomposition:
- Shared package rh_pkg holds:
  - NOTE_REST = 4'h0 and NOTE_END = 4'hF
  - FSM state encodings (IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2)
  - TEMPO_W = 26 and NOTE_W = 4
- One natural sub-module is beat_timer: it takes clk, reset_n, clear and tempo, and produces beat_end and count. It is reusable by the video scroller.
- Scoring arithmetic and the FSM live in score_tracker.

Test Plan:
- Reset then start with tempo=8, HIT_SHIFT=1, judge_note=4'h3 and det_note=3 held valid for the whole beat → judge_valid 1 cycle after beat_end; judge_hit=1, score=10, streak=1, hits=1.
- det_note matches for only 3 of 8 cycles (threshold 4) → judge_hit=0, misses=1, streak=0, score unchanged; exactly 4 matching cycles → hit.
- judge_note=0 for 3 beats with arbitrary det_note → no judge_valid pulses and all counters unchanged.
- 9 consecutive hits (STREAK_STEP=3) → scores 10×8 then +20 on the 9th hit, giving score=100, streak=9, best_streak=9; then one miss → streak=0 and best_streak=9.
- song_done asserted on the same cycle as beat_end → no judgement, playing=0, outputs frozen; then start → all counters 0 and playing=1.
- reset_n pulled low mid-beat (asynchronously, between clock edges) → all outputs 0 immediately and state IDLE; no judge_valid until the next start and a full beat have elapsed.
